cesar_decipher: RTL and testbench
=================================

# cesar_decipher

Hardware decoder for the Caesar-cipher accelerator. It reverses the in-place byte rotation the cipher component applies to a zero-terminated string in shared memory. It uses the same call/return streaming handshake and a 64-bit Avalon-MM host port, and sits beside the cipher component on the same memory. Each character is read, rotated back by `n mod 26`, and written back until the terminator byte or `MAX_LEN` is reached.

## Interface
Parameters:
- `MAX_LEN`, default 4096: hard cap on bytes processed per call. Must be ≥ 1.

Ports:
- `clock`  in  1  sole clock; all logic is rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  call.valid; a call is accepted when `start`=1 and `busy`=0.
- `busy`  out  1  call.stall; high in every state except IDLE.
- `done`  out  1  return.valid.
- `stall`  in  1  return.stall; the return transfer completes when `done`=1 and `stall`=0.
- `palavra`  in  64  byte address of the string; captured at call accept.
- `n`  in  32  unsigned shift; captured at call accept.
- `avmm_0_rw_address`  out  64  byte address of the current character.
- `avmm_0_rw_byteenable`  out  8  one-hot, equal to `1 << address[2:0]`.
- `avmm_0_rw_read`  out  1  read strobe. There is no waitrequest. Read latency is fixed at 1: `readdata` is valid in the cycle after `read`=1.
- `avmm_0_rw_readdata`  in  64  read data; the character is lane `address[2:0]`.
- `avmm_0_rw_write`  out  1  write strobe, single cycle, always accepted.
- `avmm_0_rw_writedata`  out  64  decoded byte replicated into all 8 lanes.

## Operation
- State machine: IDLE → LOAD → RD → CAP → WR → RD … → FIN → IDLE.
- **IDLE**
  - `start`=1: capture `base` = `palavra` and `n_r` = `n`, set `idx` = 0, go to LOAD.
- **LOAD**
  - Register `k` = `n_r % 26` (5 bits).
  - Go to RD.
- **RD**
  - Drive `read`=1 and `address` = `base + idx`, with 64-bit wrap-around on overflow.
  - Go to CAP.
- **CAP**
  - Latch byte `c` from lane `address[2:0]`.
  - If `c`=0x00, go to FIN; otherwise go to WR.
- **WR**
  - Drive `write`=1 with the decoded byte `d`, same address and byteenable as RD.
  - `idx` increments.
  - If the new `idx` equals `MAX_LEN`, go to FIN; otherwise go to RD.
- **FIN**
  - `done`=1.
  - Hold while `stall`=1; when `stall`=0, go to IDLE in the next cycle.
- Decoding rules:
  - `'A'..'Z'`: `d = 'A' + (c - 'A' + 26 - k) mod 26`.
  - `'a'..'z'`: the same formula based on `'a'`.
  - Every other byte: `d = c`. Non-letter bytes are still written back.
- All arithmetic is unsigned. The intermediate value `c - base + 26 - k` fits in 6 bits.
- `start` is ignored while `busy`=1.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `read`, `write` = 0.
  - `address`, `byteenable`, `writedata` = 0.
  - Internal registers = 0.
- `address`, `byteenable` and `writedata` are registered. Strobes are decoded from registered state.
- Latency for a string of L non-zero bytes followed by a terminator (L < `MAX_LEN`):
  - `done` first rises 3L+4 cycles after the edge that accepts `start`.
  - L = 0: no write occurs and `done` rises after 4 cycles.
  - L ≥ `MAX_LEN`: exactly `MAX_LEN` writes; no read of the terminator.
- `busy` rises in the cycle after accept and falls in the cycle after the return transfer.
- Boundary cases:
  - `start` asserted in the same cycle as the return transfer: ignored (`busy` is still 1).
  - `resetn` low at any point: immediate return to IDLE and all outputs go to their reset values. No partial write strobe is issued after reset.
  - `n` = 0 or any multiple of 26: every byte is rewritten unchanged.

## Configuration
- `CESAR_DECIPHER_DIGITS_EN`
  - Defined: `'0'..'9'` decode as `d = '0' + (c - '0' + 10 - n_r % 10) mod 10`. `n_r % 10` is registered in LOAD together with `k`.
  - Undefined: digits pass through unchanged and the mod-10 register is not synthesized.

## Structure
- Package `cesar_pkg`:
  - State enum `cesar_state_t`.
  - `ALPHA_LEN` = 26, `DIGIT_LEN` = 10.
  - ASCII constants `ASC_UA`, `ASC_LA`, `ASC_ZERO`.
  - Shared with the cipher component.
- Sub-module `cesar_byte_unshift`:
  - Purely combinational.
  - Inputs: `c`, `k`, and `kd` when digits are enabled.
  - Output: `d`.
  - The top level holds the FSM, counters and bus registers.

## Test plan
- "DQ\0" at 0x1000, `n`=3 → writes 0x41 ('A') to 0x1000 with byteenable 0x01, then 0x4E ('N') to 0x1001 with byteenable 0x02; `done` rises at cycle 10.
- "abc\0" at 0x2005, `n`=29 → writes "xyz" with byteenables 0x20, 0x40, 0x80; memory ends as "xyz\0".
- "Hi, 1!\0", `n`=1 → "Gh, 1!" with the macro undefined; "Gh, 0!" with `CESAR_DECIPHER_DIGITS_EN` defined.
- Empty string (first byte 0x00) → zero writes; `done` at cycle 4. Hold `stall`=1 for 5 cycles → `done` stays 1 and `busy` stays 1; `start` pulses during this window are ignored.
- `MAX_LEN`=4 with "ABCDEFG\0" and `n`=1 → exactly 4 writes ("@" never appears; 'A' decodes to 'Z'); no read at offset 4.
- `resetn` pulsed low in CAP of the second byte → all outputs reach reset values asynchronously; a fresh call afterwards completes normally.

Source files
------------

// File: rtl/cesar_pkg.sv
// cesar_pkg -- definitions shared by the Caesar cipher and decipher components.
//   cesar_state_t : control FSM states of the string walker
//   ALPHA_LEN     : letters in the alphabet (rotation modulus for letters)
//   DIGIT_LEN     : decimal digits (rotation modulus for digits)
//   ASC_UA/ASC_LA/ASC_ZERO : ASCII 'A', 'a' and '0'
package cesar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_WR   = 3'd4,
    ST_FIN  = 3'd5
  } cesar_state_t;

  localparam int ALPHA_LEN = 26;
  localparam int DIGIT_LEN = 10;

  localparam logic [7:0] ASC_UA   = 8'h41;
  localparam logic [7:0] ASC_LA   = 8'h61;
  localparam logic [7:0] ASC_ZERO = 8'h30;

endpackage

// File: rtl/cesar_byte_unshift.sv
// cesar_byte_unshift -- combinational inverse rotation of one character.
//   c  : encoded byte
//   k  : letter shift, already reduced mod 26
//   kd : digit shift, already reduced mod 10 (only with CESAR_DECIPHER_DIGITS_EN)
//   d  : decoded byte; bytes outside the rotated classes pass through
// Optional feature macro: CESAR_DECIPHER_DIGITS_EN (rotate '0'..'9' too).
module cesar_byte_unshift
  import cesar_pkg::*;
(
  input  logic [7:0] c,
  input  logic [4:0] k,
`ifdef CESAR_DECIPHER_DIGITS_EN
  input  logic [3:0] kd,
`endif
  output logic [7:0] d
);

  // Offset within the class plus the modulus minus the shift; always < 52,
  // so a single conditional subtract completes the modulo.
  logic [5:0] t;

  always_comb begin
    d = c;
    t = '0;
    if (c >= ASC_UA && c <= ASC_UA + 8'd25) begin
      t = 6'(c - ASC_UA) + 6'(ALPHA_LEN) - {1'b0, k};
      if (t >= 6'(ALPHA_LEN)) t = t - 6'(ALPHA_LEN);
      d = ASC_UA + {2'b00, t};
    end else if (c >= ASC_LA && c <= ASC_LA + 8'd25) begin
      t = 6'(c - ASC_LA) + 6'(ALPHA_LEN) - {1'b0, k};
      if (t >= 6'(ALPHA_LEN)) t = t - 6'(ALPHA_LEN);
      d = ASC_LA + {2'b00, t};
    end
`ifdef CESAR_DECIPHER_DIGITS_EN
    else if (c >= ASC_ZERO && c <= ASC_ZERO + 8'd9) begin
      t = 6'(c - ASC_ZERO) + 6'(DIGIT_LEN) - {2'b00, kd};
      if (t >= 6'(DIGIT_LEN)) t = t - 6'(DIGIT_LEN);
      d = ASC_ZERO + {2'b00, t};
    end
`endif
  end

endmodule

// File: rtl/cesar_decipher.sv
// cesar_decipher -- walks a zero-terminated string in memory and undoes the
// Caesar rotation in place, one byte per read/write pair.
//   clock, resetn        : clock, asynchronous active-low reset
//   start/busy           : call handshake (accept when start && !busy)
//   done/stall           : return handshake (completes when done && !stall)
//   palavra, n           : string byte address and shift, captured at accept
//   avmm_0_rw_*          : 64-bit Avalon-MM host, fixed read latency 1,
//                          no waitrequest, byte lane = address[2:0]
// Parameter MAX_LEN caps the bytes processed per call.
// Optional feature macro: CESAR_DECIPHER_DIGITS_EN (rotate '0'..'9' too).
module cesar_decipher
  import cesar_pkg::*;
#(
  parameter int MAX_LEN = 4096
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        stall,
  input  logic [63:0] palavra,
  input  logic [31:0] n,
  output logic [63:0] avmm_0_rw_address,
  output logic [7:0]  avmm_0_rw_byteenable,
  output logic        avmm_0_rw_read,
  input  logic [63:0] avmm_0_rw_readdata,
  output logic        avmm_0_rw_write,
  output logic [63:0] avmm_0_rw_writedata
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_LEN);

  cesar_state_t     state_q, state_d;
  logic [63:0]      base_q, base_d;
  logic [31:0]      n_q, n_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4:0]       k_q, k_d;
`ifdef CESAR_DECIPHER_DIGITS_EN
  logic [3:0]       kd_q, kd_d;
`endif
  logic [63:0]      addr_q, addr_d;
  logic [7:0]       be_q, be_d;
  logic [63:0]      wd_q, wd_d;

  logic [7:0]       lane_c;
  logic [7:0]       dec_byte;

  // Read data is valid during CAP; the character sits in the address lane.
  assign lane_c = avmm_0_rw_readdata[{addr_q[2:0], 3'b000} +: 8];

  cesar_byte_unshift u_unshift (
    .c  (lane_c),
    .k  (k_q),
`ifdef CESAR_DECIPHER_DIGITS_EN
    .kd (kd_q),
`endif
    .d  (dec_byte)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    n_d     = n_q;
    idx_d   = idx_q;
    k_d     = k_q;
`ifdef CESAR_DECIPHER_DIGITS_EN
    kd_d    = kd_q;
`endif
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = palavra;
          n_d     = n;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        k_d = 5'(n_q % 32'(ALPHA_LEN));
`ifdef CESAR_DECIPHER_DIGITS_EN
        kd_d = 4'(n_q % 32'(DIGIT_LEN));
`endif
        // Address is registered, so it is set up on the edge entering RD.
        addr_d  = base_q + 64'(idx_q);
        be_d    = 8'b1 << addr_d[2:0];
        state_d = ST_RD;
      end
      ST_RD: state_d = ST_CAP;
      ST_CAP: begin
        if (lane_c == 8'h00) begin
          state_d = ST_FIN;
        end else begin
          wd_d    = {8{dec_byte}};
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        idx_d = idx_q + 1'b1;
        if (idx_d == IDX_MAX) begin
          state_d = ST_FIN;
        end else begin
          addr_d  = base_q + 64'(idx_d);
          be_d    = 8'b1 << addr_d[2:0];
          state_d = ST_RD;
        end
      end
      ST_FIN: begin
        if (!stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      k_q     <= '0;
`ifdef CESAR_DECIPHER_DIGITS_EN
      kd_q    <= '0;
`endif
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
`ifdef CESAR_DECIPHER_DIGITS_EN
      kd_q    <= kd_d;
`endif
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
    end
  end

  // Strobes decode straight from the state register, so reset clears them
  // in the same instant it clears the state.
  assign busy                 = (state_q != ST_IDLE);
  assign done                 = (state_q == ST_FIN);
  assign avmm_0_rw_read       = (state_q == ST_RD);
  assign avmm_0_rw_write      = (state_q == ST_WR);
  assign avmm_0_rw_address    = addr_q;
  assign avmm_0_rw_byteenable = be_q;
  assign avmm_0_rw_writedata  = wd_q;

endmodule

// File: tb/tb_cesar_decipher.sv
// tb_cesar_decipher -- directed bench for cesar_decipher with a byte memory
// model on the Avalon-MM port. Two instances: default MAX_LEN and MAX_LEN=4.
module tb_cesar_decipher;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn, start, stall, sel;
  logic [63:0] palavra;
  logic [31:0] n;
  logic        start_a, start_b;

  logic        a_busy, a_done, a_read, a_write;
  logic [63:0] a_addr, a_wd;
  logic [7:0]  a_be;
  logic        b_busy, b_done, b_read, b_write;
  logic [63:0] b_addr, b_wd;
  logic [7:0]  b_be;
  logic [63:0] rdata;

  logic        m_busy, m_done, m_read, m_write;
  logic [63:0] m_addr, m_wd;
  logic [7:0]  m_be;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_read  = sel ? b_read  : a_read;
  assign m_write = sel ? b_write : a_write;
  assign m_addr  = sel ? b_addr  : a_addr;
  assign m_wd    = sel ? b_wd    : a_wd;
  assign m_be    = sel ? b_be    : a_be;

  cesar_decipher #(.MAX_LEN(4096)) dut_a (
    .clock(clock), .resetn(resetn), .start(start_a), .busy(a_busy),
    .done(a_done), .stall(stall), .palavra(palavra), .n(n),
    .avmm_0_rw_address(a_addr), .avmm_0_rw_byteenable(a_be),
    .avmm_0_rw_read(a_read), .avmm_0_rw_readdata(rdata),
    .avmm_0_rw_write(a_write), .avmm_0_rw_writedata(a_wd)
  );

  cesar_decipher #(.MAX_LEN(4)) dut_b (
    .clock(clock), .resetn(resetn), .start(start_b), .busy(b_busy),
    .done(b_done), .stall(stall), .palavra(palavra), .n(n),
    .avmm_0_rw_address(b_addr), .avmm_0_rw_byteenable(b_be),
    .avmm_0_rw_read(b_read), .avmm_0_rw_readdata(rdata),
    .avmm_0_rw_write(b_write), .avmm_0_rw_writedata(b_wd)
  );

  // Memory model: 64 KiB, read latency 1, byte-lane writes, write log.
  logic [7:0]  mem [0:65535];
  logic        ld_en = 1'b0;
  logic [15:0] ld_a;
  logic [7:0]  ld_d;
  int          wcnt = 0;
  logic        rd4_seen = 1'b0;
  logic [63:0] wr_addr [0:63];
  logic [7:0]  wr_be   [0:63];
  logic [63:0] wr_data [0:63];

  always @(posedge clock) begin
    if (ld_en) mem[ld_a] <= ld_d;
    if (m_read) begin
      for (int i = 0; i < 8; i++) rdata[8*i +: 8] <= mem[{m_addr[15:3], 3'(i)}];
      if (m_addr == 64'h5004) rd4_seen <= 1'b1;
    end
    if (m_write) begin
      for (int i = 0; i < 8; i++)
        if (m_be[i]) mem[{m_addr[15:3], 3'(i)}] <= m_wd[8*i +: 8];
      if (wcnt < 64) begin
        wr_addr[wcnt] <= m_addr;
        wr_be[wcnt]   <= m_be;
        wr_data[wcnt] <= m_wd;
      end
      wcnt <= wcnt + 1;
    end
  end

  int npass = 0;
  int ntot  = 0;

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(posedge clock); #1;
    ld_en = 1'b0;
  endtask

  task automatic load_str(input logic [15:0] a, input string s);
    for (int i = 0; i < s.len(); i++) poke(a + 16'(i), s[i]);
    poke(a + 16'(s.len()), 8'h00);
  endtask

  // Accepts a call and counts edges (accept edge = 1) until done is seen.
  task automatic do_call(input logic [63:0] b, input logic [31:0] nv, output int cyc);
    palavra = b; n = nv; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    while (m_done !== 1'b1 && cyc < 20000) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; stall = 1'b0; sel = 1'b0;
    palavra = '0; n = '0;
    repeat (2) @(posedge clock);
    #1;
    ntot++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", a_busy); else npass++;
    ntot++; if (a_done !== 1'b0) $display("FAIL reset_done got %b want 0", a_done); else npass++;
    ntot++; if ({a_read, a_write} !== 2'b00) $display("FAIL reset_strobes got %b want 00", {a_read, a_write}); else npass++;
    ntot++; if (a_addr !== 64'h0) $display("FAIL reset_addr got %h want 0", a_addr); else npass++;
    ntot++; if (a_be !== 8'h00) $display("FAIL reset_be got %h want 0", a_be); else npass++;
    ntot++; if (a_wd !== 64'h0) $display("FAIL reset_wd got %h want 0", a_wd); else npass++;
    ntot++; if (b_busy !== 1'b0) $display("FAIL reset_busy_b got %b want 0", b_busy); else npass++;
    resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_dq;
    int cyc, w0;
    load_str(16'h1000, "DQ");
    w0 = wcnt;
    do_call(64'h1000, 32'd3, cyc);
    ntot++; if (cyc !== 10) $display("FAIL dq_done_cycle got %0d want 10", cyc); else npass++;
    ntot++; if (wcnt - w0 !== 2) $display("FAIL dq_writes got %0d want 2", wcnt - w0); else npass++;
    ntot++; if (wr_addr[w0] !== 64'h1000) $display("FAIL dq_addr0 got %h want 1000", wr_addr[w0]); else npass++;
    ntot++; if (wr_be[w0] !== 8'h01) $display("FAIL dq_be0 got %h want 01", wr_be[w0]); else npass++;
    ntot++; if (wr_data[w0] !== 64'h4141414141414141) $display("FAIL dq_data0 got %h want 41x8", wr_data[w0]); else npass++;
    ntot++; if (wr_addr[w0+1] !== 64'h1001) $display("FAIL dq_addr1 got %h want 1001", wr_addr[w0+1]); else npass++;
    ntot++; if (wr_be[w0+1] !== 8'h02) $display("FAIL dq_be1 got %h want 02", wr_be[w0+1]); else npass++;
    ntot++; if (wr_data[w0+1] !== 64'h4E4E4E4E4E4E4E4E) $display("FAIL dq_data1 got %h want 4Ex8", wr_data[w0+1]); else npass++;
    @(posedge clock); #1;
    ntot++; if (a_busy !== 1'b0) $display("FAIL dq_busy_after got %b want 0", a_busy); else npass++;
  endtask

  task automatic test_abc;
    int cyc, w0;
    load_str(16'h2005, "abc");
    w0 = wcnt;
    do_call(64'h2005, 32'd29, cyc);
    ntot++; if (cyc !== 13) $display("FAIL abc_done_cycle got %0d want 13", cyc); else npass++;
    ntot++; if (wcnt - w0 !== 3) $display("FAIL abc_writes got %0d want 3", wcnt - w0); else npass++;
    ntot++; if ({wr_be[w0], wr_be[w0+1], wr_be[w0+2]} !== 24'h204080) $display("FAIL abc_be got %h want 204080", {wr_be[w0], wr_be[w0+1], wr_be[w0+2]}); else npass++;
    ntot++; if ({mem[16'h2005], mem[16'h2006], mem[16'h2007], mem[16'h2008]} !== 32'h78797A00) $display("FAIL abc_mem got %h want 78797a00", {mem[16'h2005], mem[16'h2006], mem[16'h2007], mem[16'h2008]}); else npass++;
    @(posedge clock); #1;
  endtask

  task automatic test_mixed;
    int cyc, w0;
    string exp_s;
`ifdef CESAR_DECIPHER_DIGITS_EN
    exp_s = "Gh, 0!";
`else
    exp_s = "Gh, 1!";
`endif
    load_str(16'h3000, "Hi, 1!");
    w0 = wcnt;
    do_call(64'h3000, 32'd1, cyc);
    ntot++; if (cyc !== 22) $display("FAIL mixed_done_cycle got %0d want 22", cyc); else npass++;
    ntot++; if (wcnt - w0 !== 6) $display("FAIL mixed_writes got %0d want 6", wcnt - w0); else npass++;
    for (int i = 0; i < 6; i++) begin
      ntot++;
      if (mem[16'h3000 + 16'(i)] !== exp_s[i])
        $display("FAIL mixed_byte%0d got %h want %h", i, mem[16'h3000 + 16'(i)], exp_s[i]);
      else npass++;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_empty_stall;
    int cyc, w0;
    poke(16'h4000, 8'h00);
    w0 = wcnt;
    stall = 1'b1;
    do_call(64'h4000, 32'd5, cyc);
    ntot++; if (cyc !== 4) $display("FAIL empty_done_cycle got %0d want 4", cyc); else npass++;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; palavra = 64'h1000;
      @(posedge clock); #1;
      ntot++; if ({a_done, a_busy} !== 2'b11) $display("FAIL stall_hold%0d got done,busy=%b want 11", i, {a_done, a_busy}); else npass++;
    end
    // start stays high through the return transfer and must be ignored.
    stall = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    ntot++; if ({a_done, a_busy} !== 2'b00) $display("FAIL ret_same_cycle got done,busy=%b want 00", {a_done, a_busy}); else npass++;
    @(posedge clock); #1;
    ntot++; if (a_busy !== 1'b0) $display("FAIL start_ignored got busy=%b want 0", a_busy); else npass++;
    ntot++; if (wcnt - w0 !== 0) $display("FAIL empty_writes got %0d want 0", wcnt - w0); else npass++;
  endtask

  task automatic test_maxlen;
    int cyc, w0;
    sel = 1'b1;
    load_str(16'h5000, "ABCDEFG");
    w0 = wcnt;
    do_call(64'h5000, 32'd1, cyc);
    ntot++; if (cyc !== 14) $display("FAIL max_done_cycle got %0d want 14", cyc); else npass++;
    ntot++; if (wcnt - w0 !== 4) $display("FAIL max_writes got %0d want 4", wcnt - w0); else npass++;
    ntot++; if ({mem[16'h5000], mem[16'h5001], mem[16'h5002], mem[16'h5003]} !== 32'h5A414243) $display("FAIL max_mem got %h want 5a414243", {mem[16'h5000], mem[16'h5001], mem[16'h5002], mem[16'h5003]}); else npass++;
    ntot++; if (mem[16'h5004] !== 8'h45) $display("FAIL max_untouched got %h want 45", mem[16'h5004]); else npass++;
    ntot++; if (rd4_seen !== 1'b0) $display("FAIL max_no_read4 got %b want 0", rd4_seen); else npass++;
    ntot++; if (wr_be[w0+3] !== 8'h08) $display("FAIL max_be3 got %h want 08", wr_be[w0+3]); else npass++;
    @(posedge clock); #1;
    ntot++; if (b_busy !== 1'b0) $display("FAIL max_busy_after got %b want 0", b_busy); else npass++;
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    int cyc, w0;
    load_str(16'h6000, "KL");
    w0 = wcnt;
    palavra = 64'h6000; n = 32'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    ntot++; if ({a_busy, a_read, a_write} !== 3'b100) $display("FAIL mid_in_cap got busy,rd,wr=%b want 100", {a_busy, a_read, a_write}); else npass++;
    #2 resetn = 1'b0;
    #1;
    ntot++; if ({a_busy, a_done, a_read, a_write} !== 4'b0000) $display("FAIL mid_rst_ctrl got %b want 0000", {a_busy, a_done, a_read, a_write}); else npass++;
    ntot++; if ({a_addr, a_be, a_wd} !== 136'h0) $display("FAIL mid_rst_bus got %h want 0", {a_addr, a_be, a_wd}); else npass++;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    @(posedge clock); #1;
    ntot++; if (wcnt - w0 !== 1) $display("FAIL mid_writes got %0d want 1", wcnt - w0); else npass++;
    ntot++; if ({mem[16'h6000], mem[16'h6001]} !== 16'h494C) $display("FAIL mid_mem got %h want 494c", {mem[16'h6000], mem[16'h6001]}); else npass++;
    do_call(64'h6001, 32'd2, cyc);
    ntot++; if (cyc !== 7) $display("FAIL fresh_done_cycle got %0d want 7", cyc); else npass++;
    ntot++; if (mem[16'h6001] !== 8'h4A) $display("FAIL fresh_mem got %h want 4a", mem[16'h6001]); else npass++;
    @(posedge clock); #1;
    ntot++; if (a_busy !== 1'b0) $display("FAIL fresh_busy_after got %b want 0", a_busy); else npass++;
  endtask

  initial begin
    test_reset();
    test_dq();
    test_abc();
    test_mixed();
    test_empty_stall();
    test_maxlen();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
